// File: rtl/carpma_denetleyici_if.sv
// Bundles the pipeline handshake and the multiplier request/response signals
// that the multiply sequencer uses.
interface carpma_denetleyici_if;
   logic        gecerli_g;
   logic        hazir_c;
   logic [1:0]  islem_g;
   logic [31:0] rs1_g;
   logic [31:0] rs2_g;
   logic        bosalt_g;
   logic        sonuc_gecerli_c;
   logic [31:0] sonuc_c;
   logic        sonuc_hazir_g;
   logic [31:0] carp_a_c;
   logic [31:0] carp_b_c;
   logic        carp_a_isaretli_c;
   logic        carp_b_isaretli_c;
   logic        carp_istek_c;
   logic [63:0] carp_sonuc_g;
   logic        carp_bitti_g;

   // The sequencer itself.
   modport slave (
      input  gecerli_g, islem_g, rs1_g, rs2_g, bosalt_g, sonuc_hazir_g,
      input  carp_sonuc_g, carp_bitti_g,
      output hazir_c, sonuc_gecerli_c, sonuc_c,
      output carp_a_c, carp_b_c, carp_a_isaretli_c, carp_b_isaretli_c, carp_istek_c
   );

   // The pipeline and the multiplier seen together as the other side.
   modport master (
      output gecerli_g, islem_g, rs1_g, rs2_g, bosalt_g, sonuc_hazir_g,
      output carp_sonuc_g, carp_bitti_g,
      input  hazir_c, sonuc_gecerli_c, sonuc_c,
      input  carp_a_c, carp_b_c, carp_a_isaretli_c, carp_b_isaretli_c, carp_istek_c
   );
endinterface

// File: rtl/carpma_denetleyici.sv
// Execute-stage sequencer for RV32M MUL/MULH/MULHSU/MULHU in front of the
// iki_bit_adimli_carpici multiplier, with a one-entry last-product cache.
module carpma_denetleyici #(
   parameter int ONBELLEK_ETKIN  = 1,
   parameter int BOSALTMA_SURESI = 18
) (
   input  logic                 clk,
   input  logic                 rst_n,
   carpma_denetleyici_if.slave  bus
);

   localparam int SAYAC_W = (BOSALTMA_SURESI > 1) ? $clog2(BOSALTMA_SURESI) : 1;

   localparam logic [1:0] ISLEM_MUL    = 2'b00;
   localparam logic [1:0] ISLEM_MULH   = 2'b01;
   localparam logic [1:0] ISLEM_MULHSU = 2'b10;

   typedef enum logic [2:0] {
      BASLAT,
      BOSTA,
      ISTEK,
      BEKLE,
      SONUC,
      DRAIN
   } durum_t;

   durum_t              r_durum;
   durum_t              w_sonrakiDurum;
   logic [SAYAC_W-1:0]  r_sayac;

   logic [31:0]         r_a;
   logic [31:0]         r_b;
   logic                r_aIsr;
   logic                r_bIsr;
   logic [1:0]          r_islem;
   logic [63:0]         r_carpim;

   logic [31:0]         r_onA;
   logic [31:0]         r_onB;
   logic                r_onAIsr;
   logic                r_onBIsr;
   logic [63:0]         r_onCarpim;
   logic                r_onGecerli;

   logic                w_aIsr;
   logic                w_bIsr;
   logic                w_kabul;
   logic                w_isabet;
   logic                w_yakala;
   logic                w_iptal;
   logic                w_hazir;
   logic                w_sonucGecerli;
   logic                w_istek;

   assign w_aIsr = (bus.islem_g == ISLEM_MULH) || (bus.islem_g == ISLEM_MULHSU);
   assign w_bIsr = (bus.islem_g == ISLEM_MULH);

   // A flush on the same edge wins over an accept.
   assign w_kabul = bus.gecerli_g && (r_durum == BOSTA) && !bus.bosalt_g;

   // The low word is the same for any signedness, so MUL ignores the sign bits.
   assign w_isabet = (ONBELLEK_ETKIN != 0) && r_onGecerli
                     && (bus.rs1_g == r_onA) && (bus.rs2_g == r_onB)
                     && ((bus.islem_g == ISLEM_MUL)
                         || ((w_aIsr == r_onAIsr) && (w_bIsr == r_onBIsr)));

   assign w_yakala = (r_durum == BEKLE) && bus.carp_bitti_g && !bus.bosalt_g;
   assign w_iptal  = ((r_durum == ISTEK) || (r_durum == BEKLE)) && bus.bosalt_g;

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         r_durum <= BASLAT;
      end else begin
         r_durum <= w_sonrakiDurum;
      end
   end

   always_comb begin
      w_sonrakiDurum = r_durum;
      w_hazir        = 1'b0;
      w_sonucGecerli = 1'b0;
      w_istek        = 1'b0;
      case (r_durum)
         BASLAT: begin
            if (r_sayac == '0) begin
               w_sonrakiDurum = BOSTA;
            end
         end
         BOSTA: begin
            w_hazir = 1'b1;
            if (w_kabul) begin
               w_sonrakiDurum = w_isabet ? SONUC : ISTEK;
            end
         end
         ISTEK: begin
            w_istek        = 1'b1;
            w_sonrakiDurum = bus.bosalt_g ? DRAIN : BEKLE;
         end
         BEKLE: begin
            if (bus.bosalt_g) begin
               w_sonrakiDurum = bus.carp_bitti_g ? BOSTA : DRAIN;
            end else if (bus.carp_bitti_g) begin
               w_sonrakiDurum = SONUC;
            end
         end
         SONUC: begin
            w_sonucGecerli = 1'b1;
            if (bus.bosalt_g || bus.sonuc_hazir_g) begin
               w_sonrakiDurum = BOSTA;
            end
         end
         DRAIN: begin
            if (bus.carp_bitti_g) begin
               w_sonrakiDurum = BOSTA;
            end
         end
         default: begin
            w_sonrakiDurum = BASLAT;
         end
      endcase
   end

   // The multiplier has no reset, so after reset we wait long enough for any
   // operation it still has in flight to finish before issuing a new one.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         r_sayac <= SAYAC_W'(BOSALTMA_SURESI - 1);
      end else if ((r_durum == BASLAT) && (r_sayac != '0)) begin
         r_sayac <= r_sayac - SAYAC_W'(1);
      end
   end

   // Multiplier inputs come only from these registers: the multiplier applies
   // its sign correction from the live inputs when it finishes.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         r_a         <= '0;
         r_b         <= '0;
         r_aIsr      <= 1'b0;
         r_bIsr      <= 1'b0;
         r_islem     <= ISLEM_MUL;
         r_carpim    <= '0;
         r_onA       <= '0;
         r_onB       <= '0;
         r_onAIsr    <= 1'b0;
         r_onBIsr    <= 1'b0;
         r_onCarpim  <= '0;
         r_onGecerli <= 1'b0;
      end else begin
         if (w_kabul) begin
            r_islem <= bus.islem_g;
            if (w_isabet) begin
               r_carpim <= r_onCarpim;
            end else begin
               r_a    <= bus.rs1_g;
               r_b    <= bus.rs2_g;
               r_aIsr <= w_aIsr;
               r_bIsr <= w_bIsr;
            end
         end
         if (w_yakala) begin
            r_carpim    <= bus.carp_sonuc_g;
            r_onCarpim  <= bus.carp_sonuc_g;
            r_onA       <= r_a;
            r_onB       <= r_b;
            r_onAIsr    <= r_aIsr;
            r_onBIsr    <= r_bIsr;
            r_onGecerli <= 1'b1;
         end else if (w_iptal) begin
            r_onGecerli <= 1'b0;
         end
      end
   end

   assign bus.hazir_c           = w_hazir;
   assign bus.sonuc_gecerli_c   = w_sonucGecerli;
   assign bus.sonuc_c           = (r_islem == ISLEM_MUL) ? r_carpim[31:0] : r_carpim[63:32];
   assign bus.carp_istek_c      = w_istek;
   assign bus.carp_a_c          = r_a;
   assign bus.carp_b_c          = r_b;
   assign bus.carp_a_isaretli_c = r_aIsr;
   assign bus.carp_b_isaretli_c = r_bIsr;

endmodule

// File: tb/tb_carpma_denetleyici.sv
// Self-checking bench for carpma_denetleyici: directed cases plus randomized
// operations checked against an arithmetic model of RV32M multiplies.
module tb_carpma_denetleyici;

   localparam int BOSALTMA = 18;
   localparam int MISS_LAT = 18;

   logic clk   = 1'b0;
   logic rst_n = 1'b0;
   always #5 clk = ~clk;

   carpma_denetleyici_if bus ();

   carpma_denetleyici #(
      .ONBELLEK_ETKIN  (1),
      .BOSALTMA_SURESI (BOSALTMA)
   ) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus)
   );

   int testsRun    = 0;
   int testsFailed = 0;

   task automatic checkOutput(input string tag, input logic [63:0] observed, input logic [63:0] expected);
      testsRun++;
      if (observed !== expected) begin
         testsFailed++;
         $display("[TB] FAIL %s: observed 0x%0h, expected 0x%0h", tag, observed, expected);
      end
   endtask

   // Stand-in for iki_bit_adimli_carpici: starts on a sampled istek, pulses bitti
   // sixteen edges later, and signs the product from its live inputs. No reset.
   logic        mulBusy  = 1'b0;
   int          mulRem   = 0;
   logic        mulBitti = 1'b0;
   logic [63:0] mulSonuc = '0;

   assign bus.carp_bitti_g = mulBitti;
   assign bus.carp_sonuc_g = mulSonuc;

   function automatic logic [63:0] mulProduct(input logic [31:0] a, input logic [31:0] b,
                                              input logic sa, input logic sb);
      logic [63:0] ea;
      logic [63:0] eb;
      ea = sa ? {{32{a[31]}}, a} : {32'h0, a};
      eb = sb ? {{32{b[31]}}, b} : {32'h0, b};
      return ea * eb;
   endfunction

   always @(posedge clk) begin
      mulBitti <= 1'b0;
      if (bus.carp_istek_c) begin
         checkOutput("istek_while_busy", mulBusy, 1'b0);
      end
      if (mulBusy) begin
         if (mulRem == 1) begin
            mulBitti <= 1'b1;
            mulSonuc <= mulProduct(bus.carp_a_c, bus.carp_b_c,
                                   bus.carp_a_isaretli_c, bus.carp_b_isaretli_c);
            mulBusy  <= 1'b0;
         end
         mulRem <= mulRem - 1;
      end else if (bus.carp_istek_c) begin
         mulBusy <= 1'b1;
         mulRem  <= 16;
      end
   end

   // Reference: RV32M result from 64-bit integer arithmetic.
   function automatic logic [31:0] refResult(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b);
      int          ia;
      int          ib;
      longint      prod;
      logic [63:0] bits;
      ia = a;
      ib = b;
      case (op)
         2'b00:   prod = longint'(ia) * longint'(ib);
         2'b01:   prod = longint'(ia) * longint'(ib);
         2'b10:   prod = longint'(ia) * longint'(b);
         default: prod = longint'(a)  * longint'(b);
      endcase
      bits = prod;
      return (op == 2'b00) ? bits[31:0] : bits[63:32];
   endfunction

   // Reference view of the last-product cache.
   bit          refValid = 1'b0;
   logic [31:0] refA     = '0;
   logic [31:0] refB     = '0;
   bit          refSa    = 1'b0;
   bit          refSb    = 1'b0;

   task automatic waitDrain(input string tag);
      int cnt;
      cnt = 0;
      while (!bus.hazir_c && cnt < 60) begin
         cnt++;
         @(posedge clk); #1;
      end
      checkOutput(tag, cnt, BOSALTMA);
   endtask

   task automatic waitReady();
      int waitCnt;
      waitCnt = 0;
      while (!bus.hazir_c && waitCnt < 100) begin
         @(posedge clk); #1;
         waitCnt++;
      end
      checkOutput("ready_wait", waitCnt < 100, 1'b1);
   endtask

   task automatic applyStimulus(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b,
                                input int holdCycles, input bit dropResult);
      int          lat;
      int          istekCnt;
      bit          hit;
      bit          expSa;
      bit          expSb;
      bit          hazirSeen;
      bit          operandsMoved;
      bit          heldOk;
      logic [31:0] firstResult;

      expSa = (op == 2'b01) || (op == 2'b10);
      expSb = (op == 2'b01);
      hit   = refValid && (a == refA) && (b == refB)
              && ((op == 2'b00) || ((expSa == refSa) && (expSb == refSb)));

      waitReady();
      bus.gecerli_g = 1'b1;
      bus.islem_g   = op;
      bus.rs1_g     = a;
      bus.rs2_g     = b;
      @(posedge clk); #1;
      bus.gecerli_g = 1'b0;
      bus.rs1_g     = $urandom;
      bus.rs2_g     = $urandom;
      bus.islem_g   = 2'($urandom);

      lat           = 0;
      istekCnt      = 0;
      hazirSeen     = 1'b0;
      operandsMoved = 1'b0;
      while (!bus.sonuc_gecerli_c && lat < 60) begin
         if (bus.carp_istek_c) istekCnt++;
         if (bus.hazir_c) hazirSeen = 1'b1;
         if (bus.carp_a_c !== a || bus.carp_b_c !== b
             || bus.carp_a_isaretli_c !== expSa || bus.carp_b_isaretli_c !== expSb) begin
            operandsMoved = 1'b1;
         end
         @(posedge clk); #1;
         lat++;
      end

      // A hit shows its result in the cycle right after the accepting edge.
      checkOutput("latency", lat, hit ? 0 : MISS_LAT);
      checkOutput("istek_pulses", istekCnt, hit ? 0 : 1);
      if (!hit) begin
         checkOutput("hazir_while_busy", hazirSeen, 1'b0);
         checkOutput("operands_held", operandsMoved, 1'b0);
         refA  = a;
         refB  = b;
         refSa = expSa;
         refSb = expSb;
      end
      refValid = 1'b1;
      checkOutput("result", bus.sonuc_c, refResult(op, a, b));

      firstResult = bus.sonuc_c;
      heldOk      = 1'b1;
      for (int i = 0; i < holdCycles; i++) begin
         @(posedge clk); #1;
         if (!bus.sonuc_gecerli_c || bus.sonuc_c !== firstResult || bus.hazir_c) heldOk = 1'b0;
      end
      if (holdCycles > 0) checkOutput("backpressure_hold", heldOk, 1'b1);

      if (dropResult) bus.bosalt_g = 1'b1;
      else            bus.sonuc_hazir_g = 1'b1;
      @(posedge clk); #1;
      bus.bosalt_g      = 1'b0;
      bus.sonuc_hazir_g = 1'b0;
      checkOutput("release_valid", bus.sonuc_gecerli_c, 1'b0);
      checkOutput("release_ready", bus.hazir_c, 1'b1);
   endtask

   task automatic flushDuringWait(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b);
      int cnt;
      int istekCnt;
      bit sawValid;
      waitReady();
      bus.gecerli_g = 1'b1;
      bus.islem_g   = op;
      bus.rs1_g     = a;
      bus.rs2_g     = b;
      @(posedge clk); #1;
      bus.gecerli_g = 1'b0;
      cnt      = 0;
      istekCnt = bus.carp_istek_c ? 1 : 0;
      sawValid = 1'b0;
      while (!bus.hazir_c && cnt < 60) begin
         @(posedge clk); #1;
         cnt++;
         bus.bosalt_g = (cnt == 5);
         if (bus.carp_istek_c) istekCnt++;
         if (bus.sonuc_gecerli_c) sawValid = 1'b1;
      end
      bus.bosalt_g = 1'b0;
      refValid     = 1'b0;
      checkOutput("flush_istek", istekCnt, 1);
      checkOutput("flush_no_result", sawValid, 1'b0);
      checkOutput("flush_drain_cycles", cnt, MISS_LAT);
   endtask

   task automatic resetDuringMiss(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b);
      waitReady();
      bus.gecerli_g = 1'b1;
      bus.islem_g   = op;
      bus.rs1_g     = a;
      bus.rs2_g     = b;
      @(posedge clk); #1;
      bus.gecerli_g = 1'b0;
      repeat (9) begin
         @(posedge clk); #1;
      end
      rst_n = 1'b0;
      @(posedge clk); #1;
      rst_n    = 1'b1;
      refValid = 1'b0;
      checkOutput("midreset_valid", bus.sonuc_gecerli_c, 1'b0);
      checkOutput("midreset_istek", bus.carp_istek_c, 1'b0);
      checkOutput("midreset_a", bus.carp_a_c, 32'h0);
      waitDrain("midreset_drain");
   endtask

   function automatic logic [31:0] randOperand();
      case ($urandom_range(0, 4))
         0:       return 32'h8000_0000;
         1:       return 32'hFFFF_FFFF;
         2:       return 32'($urandom_range(0, 15));
         default: return $urandom;
      endcase
   endfunction

   initial begin
      #1_000_000;
      $display("[TB] FAIL watchdog: simulation time limit reached before the bench finished");
      $fatal(1, "[TB] watchdog expired");
   end

   initial begin
      logic [1:0]  op;
      logic [31:0] a;
      logic [31:0] b;
      logic [31:0] lastA;
      logic [31:0] lastB;

      bus.gecerli_g     = 1'b0;
      bus.islem_g       = 2'b00;
      bus.rs1_g         = '0;
      bus.rs2_g         = '0;
      bus.bosalt_g      = 1'b0;
      bus.sonuc_hazir_g = 1'b0;

      rst_n = 1'b0;
      repeat (3) begin
         @(posedge clk); #1;
      end
      checkOutput("reset_hazir", bus.hazir_c, 1'b0);
      checkOutput("reset_valid", bus.sonuc_gecerli_c, 1'b0);
      checkOutput("reset_sonuc", bus.sonuc_c, 32'h0);
      checkOutput("reset_istek", bus.carp_istek_c, 1'b0);
      checkOutput("reset_operands", {bus.carp_a_c, bus.carp_b_c}, 64'h0);
      checkOutput("reset_signs", {bus.carp_a_isaretli_c, bus.carp_b_isaretli_c}, 2'b00);
      rst_n = 1'b1;
      waitDrain("startup_drain");

      $display("[TB] directed cases");
      applyStimulus(2'b11, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 0, 1'b0);
      applyStimulus(2'b00, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 0, 1'b0);
      applyStimulus(2'b01, 32'hFFFF_FFFE, 32'h0000_0003, 0, 1'b0);
      applyStimulus(2'b10, 32'hFFFF_FFFF, 32'h0000_0002, 0, 1'b0);
      applyStimulus(2'b11, 32'hFFFF_FFFF, 32'h0000_0002, 0, 1'b0);
      applyStimulus(2'b00, 32'h0000_1234, 32'h0000_0010, 5, 1'b0);

      flushDuringWait(2'b01, 32'h1234_5678, 32'h9ABC_DEF0);
      applyStimulus(2'b00, 32'h0000_0007, 32'h0000_0006, 0, 1'b0);

      applyStimulus(2'b01, 32'h8000_0000, 32'h8000_0000, 2, 1'b1);
      applyStimulus(2'b00, 32'h8000_0000, 32'h8000_0000, 0, 1'b0);

      waitReady();
      bus.gecerli_g = 1'b1;
      bus.bosalt_g  = 1'b1;
      bus.islem_g   = 2'b00;
      bus.rs1_g     = 32'd3;
      bus.rs2_g     = 32'd5;
      @(posedge clk); #1;
      bus.gecerli_g = 1'b0;
      bus.bosalt_g  = 1'b0;
      checkOutput("flush_beats_accept_ready", bus.hazir_c, 1'b1);
      checkOutput("flush_beats_accept_istek", bus.carp_istek_c, 1'b0);
      checkOutput("flush_beats_accept_valid", bus.sonuc_gecerli_c, 1'b0);
      applyStimulus(2'b00, 32'd3, 32'd5, 0, 1'b0);

      resetDuringMiss(2'b01, 32'h7654_3210, 32'h0BAD_F00D);
      applyStimulus(2'b11, 32'h0001_0000, 32'h0001_0000, 0, 1'b0);

      $display("[TB] randomized operations");
      lastA = 32'h0001_0000;
      lastB = 32'h0001_0000;
      for (int n = 0; n < 40; n++) begin
         op = 2'($urandom_range(0, 3));
         if ($urandom_range(0, 2) == 0) begin
            a = lastA;
            b = lastB;
         end else begin
            a = randOperand();
            b = randOperand();
         end
         applyStimulus(op, a, b, $urandom_range(0, 3), ($urandom_range(0, 7) == 0));
         lastA = a;
         lastB = b;
      end

      $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
      $finish;
   end

endmodule

// File: doc/carpma_denetleyici.md
Name: carpma_denetleyici

Overview:
- Sequencer for the RV32M multiply instructions (MUL, MULH, MULHSU, MULHU) in the execute stage.
- Accepts one operation at a time from the pipeline over a valid/ready handshake and decodes it into the iki_bit_adimli_carpici request: operands plus per-operand signedness.
- Holds the multiplier inputs stable, captures the 64-bit product on bitti, and returns the selected 32-bit half downstream.
- A one-entry product cache lets back-to-back MULH/MUL pairs on the same operands skip the multiplier.

Parameters:
- ONBELLEK_ETKIN, 1, 1 enables the last-product cache; 0 forces every operation through the multiplier.
- BOSALTMA_SURESI, 18, cycles hazir_c is held low after reset so that any multiplier operation still in flight drains.

Ports:
- clk  input  1  clock; all state updates on the rising edge.
- rst_n  input  1  synchronous, active-low reset.
- gecerli_g  input  1  upstream operation valid.
- hazir_c  output  1  ready; an operation is accepted on the edge where gecerli_g & hazir_c.
- islem_g  input  2  funct3[1:0] encoding: 00 MUL, 01 MULH, 10 MULHSU, 11 MULHU.
- rs1_g  input  32  operand A.
- rs2_g  input  32  operand B.
- bosalt_g  input  1  pipeline flush; discards the pending operation.
- sonuc_gecerli_c  output  1  result valid.
- sonuc_c  output  32  result.
- sonuc_hazir_g  input  1  downstream accepts the result when sonuc_gecerli_c & sonuc_hazir_g.
- carp_a_c  output  32  to multiplier a_g.
- carp_b_c  output  32  to multiplier b_g.
- carp_a_isaretli_c  output  1  to multiplier a_isaretli.
- carp_b_isaretli_c  output  1  to multiplier b_isaretli.
- carp_istek_c  output  1  to multiplier istek.
- carp_sonuc_g  input  64  from multiplier sonuc.
- carp_bitti_g  input  1  from multiplier bitti (one-cycle pulse).

Behaviour:
- **Reset values:** hazir_c=0, sonuc_gecerli_c=0, sonuc_c=0, carp_istek_c=0, carp_* operand outputs 0, cache valid=0. The state machine enters BASLAT with the drain counter set to BOSALTMA_SURESI-1.
- **Operand and signedness registers:** latched on accept and driven to the multiplier from registers, never combinationally from rs*_g.
  - Signedness (a,b): MULH (1,1), MULHSU (1,0), MULHU (0,0), MUL (0,0).
  - The multiplier applies its sign correction to sonuc from the live a_g/b_g, so carp_a_c/carp_b_c/isaretli must stay unchanged from ISTEK until the product is captured.
- **State machine:**
  - BASLAT: hazir_c=0; count down to 0, then go to BOSTA.
  - BOSTA: hazir_c=1. On accept:
    - cache hit: go to SONUC, latency 1 cycle.
    - otherwise: go to ISTEK.
  - ISTEK: carp_istek_c=1 for exactly one cycle, then go to BEKLE.
  - BEKLE: on carp_bitti_g=1, capture carp_sonuc_g into the 64-bit product and cache registers, then go to SONUC.
  - SONUC: sonuc_gecerli_c=1 and sonuc_c stable. Hold until sonuc_hazir_g=1, then go to BOSTA.
  - DRAIN: hazir_c=0; wait for carp_bitti_g, discard the product, invalidate the cache, go to BOSTA.
- **Result select:** MUL returns product[31:0]; all other operations return product[63:32].
- **Miss latency:** accept at edge E0 → istek sampled at E1 → bitti high after E17 → captured at E18 → sonuc_gecerli_c high from E18. Total 18 cycles.
- **Cache hit rule:** requires ONBELLEK_ETKIN=1, cache valid, and rs1_g/rs2_g equal to the cached operands.
  - MUL hits on any signedness, because the low word is signedness-independent.
  - MULH/MULHSU/MULHU additionally require equal signedness bits.
- **Flush:**
  - In ISTEK or BEKLE: go to DRAIN; no result is produced. If bitti arrives on the same edge as bosalt_g, the product is discarded and the block goes to BOSTA.
  - In SONUC: go to BOSTA, drop the result; the cache stays valid.
  - bosalt_g has priority over an accept on the same edge: nothing is accepted.
- **Reset mid-operation:** the multiplier has no reset, so the BASLAT hold guarantees it is idle before the next istek.
- **Protocol:** carp_istek_c is never asserted unless the multiplier is known idle. hazir_c is low in every state except BOSTA, so there is no overlap between operations.

Test Plan:
- **MULHU miss:** MULHU 0xFFFFFFFF×0xFFFFFFFF → sonuc_c=0xFFFFFFFE, sonuc_gecerli_c high exactly 18 cycles after accept, carp_istek_c high for one cycle.
- **MUL hit after MULHU:** then MUL with the same operands → cache hit, sonuc_c=0x00000001 one cycle after accept, carp_istek_c stays 0.
- **Signed variants:**
  - MULH 0xFFFFFFFE×0x00000003 → 0xFFFFFFFF.
  - MULHSU 0xFFFFFFFF×0x00000002 → 0xFFFFFFFF.
  - MULHU with the same operands as MULHSU → 0x00000001, and must miss the cache.
- **Backpressure:** sonuc_hazir_g=0 for 5 cycles → sonuc_c and sonuc_gecerli_c held stable, hazir_c=0; released → BOSTA next cycle.
- **Flush in BEKLE:** bosalt_g at cycle 6 after accept → no sonuc_gecerli_c, hazir_c stays 0 until the cycle after bitti, next MUL 7×6 → 0x0000002A via a miss.
- **Reset mid-operation:** rst_n low for 1 cycle at cycle 10 of a miss → hazir_c=0 for 18 cycles, then the next MULHU 0x10000×0x10000 → 0x00000001.
